fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000000, meaning the instruction word driven into IF/ID on a bubble or flush.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  meaning the ID stage requests that IF/ID hold its contents.
REQ-006 SHALL have port branch_taken  input  1  meaning redirect fetch to branch_target (branch resolved in EX/MEM).
REQ-007 SHALL have port branch_target  input  32  meaning the redirect byte address.
REQ-008 SHALL have port imem_addr  output  32  meaning the instruction memory byte address, equal to the current PC.
REQ-009 SHALL have port imem_req  output  1  meaning the fetch request to instruction memory.
REQ-010 SHALL have port imem_rdata  input  32  meaning the instruction word, valid only when imem_ready=1.
REQ-011 SHALL have port imem_ready  input  1  meaning imem_rdata corresponds to imem_addr in this cycle.
REQ-012 SHALL have port if_id_pc4  output  32  meaning the registered PC+4 of the instruction held in IF/ID.
REQ-013 SHALL have port if_id_instr  output  32  meaning the registered instruction word held in IF/ID.
REQ-014 SHALL have port if_id_valid  output  1  meaning the IF/ID contents are a real instruction rather than a bubble.
REQ-015 SHALL have port fetch_count  output  32  meaning the count of instructions delivered into IF/ID.

Function
REQ-016 SHALL implement two states, FETCH and HOLD; imem_req=1 in FETCH only; imem_addr=pc in both states.
REQ-017 FETCH, imem_ready=1, stall=0: IF/ID <= {pc+4, imem_rdata, valid=1}; pc <= pc+4; state remains FETCH.
REQ-018 FETCH, imem_ready=1, stall=1: IF/ID holds; skid <= {pc+4, imem_rdata}; pc <= pc+4; state -> HOLD.
REQ-019 FETCH, imem_ready=0, stall=0: IF/ID <= {pc+4, NOP_INSTR, valid=0}; pc holds.
REQ-020 FETCH, imem_ready=0, stall=1: IF/ID holds; pc holds.
REQ-021 HOLD, stall=1: IF/ID, skid and pc hold; imem_req=0.
REQ-022 HOLD, stall=0: IF/ID <= {skid, valid=1}; state -> FETCH.
REQ-023 branch_taken=1 SHALL override all other inputs, including stall: pc <= {branch_target[31:2],2'b00}; IF/ID <= {32'h0, NOP_INSTR, valid=0}; skid discarded; state -> FETCH; fetch_count unchanged.
REQ-024 Latency: an instruction accepted with imem_ready=1 and stall=0 SHALL appear in IF/ID on the next rising edge.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-026 fetch_count SHALL increment by 1 on every edge on which IF/ID loads with valid=1 (REQ-017, REQ-022), and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-027 pc[1:0] SHALL always be 2'b00.
REQ-028 No instruction SHALL be lost or duplicated across any stall/ready interleaving that contains no branch.

Reset
REQ-029 rst=1 SHALL set the following on the next edge: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc4=0, skid=0, fetch_count=0.
REQ-030 rst SHALL override branch_taken, stall and imem_ready.
REQ-031 rst asserted in HOLD SHALL discard the skid contents.
REQ-032 Fetch SHALL resume at RESET_PC on the first edge after rst is deasserted.

Verification
REQ-033 Reset, then ready=1 and stall=0 for 3 cycles with rdata=A,B,C -> IF/ID shows (4,A), (8,B), (12,C), all valid; fetch_count=3.
REQ-034 ready=1, stall=1 at pc=8 with rdata=X, stall for 2 more cycles -> imem_req=0 in HOLD; IF/ID unchanged.
REQ-034 (cont.) Stall then released -> IF/ID=(12,X,valid=1); next fetch issues at imem_addr=12.
REQ-035 ready=0 for 2 cycles at pc=16 -> 2 bubbles (valid=0, instr=NOP_INSTR); imem_addr stays 16.
REQ-036 branch_taken=1 with target 32'h00000103 while in HOLD with stall=1 -> next edge: pc=0x100, state FETCH, if_id_valid=0, skid dropped, fetch_count unchanged.
REQ-037 PC preset near the top of the address space, ready=1 at pc=0xFFFFFFFC -> if_id_pc4=0, pc wraps to 0.
REQ-038 fetch_count forced to 0xFFFFFFFF, then one valid delivery -> fetch_count=0.
REQ-039 rst=1 asserted mid-HOLD -> next edge: all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// one-entry skid buffer that keeps a word fetched while ID is stalled.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            pc4_q        <= 32'h0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            skid_pc4_q   <= 32'h0;
            skid_instr_q <= 32'h0;
            count_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;
        count_d      = count_q;

        if (branch_taken) begin
            // Redirect beats any stall; a parked skid word is wrong-path.
            state_d      = FETCH;
            pc_d         = {branch_target[31:2], 2'b00};
            pc4_d        = 32'h0;
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            skid_pc4_d   = 32'h0;
            skid_instr_d = 32'h0;
        end else begin
            case (state_q)
                FETCH: begin
                    unique case (1'b1)
                        imem_ready && !stall: begin
                            pc_d    = pc_plus4;
                            pc4_d   = pc_plus4;
                            instr_d = imem_rdata;
                            valid_d = 1'b1;
                            count_d = count_q + 32'd1;
                        end
                        imem_ready && stall: begin
                            pc_d         = pc_plus4;
                            skid_pc4_d   = pc_plus4;
                            skid_instr_d = imem_rdata;
                            state_d      = HOLD;
                        end
                        !imem_ready && !stall: begin
                            pc4_d   = pc_plus4;
                            instr_d = NOP_INSTR;
                            valid_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (!stall) begin
                        pc4_d   = skid_pc4_q;
                        instr_d = skid_instr_q;
                        valid_d = 1'b1;
                        count_d = count_q + 32'd1;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == FETCH);
    assign if_id_pc4   = pc4_q;
    assign if_id_instr = instr_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, stall/skid, bubbles, branch,
// PC and counter wrap, reset in HOLD.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_addr, hi_addr;
    logic        imem_req, hi_req;
    logic [31:0] if_id_pc4, hi_pc4;
    logic [31:0] if_id_instr, hi_instr;
    logic        if_id_valid, hi_valid;
    logic [31:0] fetch_count, hi_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)) dut_hi (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(hi_addr), .imem_req(hi_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .if_id_pc4(hi_pc4), .if_id_instr(hi_instr),
        .if_id_valid(hi_valid), .fetch_count(hi_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc4,
                              input logic [31:0] instr, input logic valid,
                              input logic [31:0] cnt);
        check({tag, ".pc4"}, if_id_pc4, pc4);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, valid});
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    task automatic check_imem(input string tag, input logic [31:0] addr,
                              input logic req);
        check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
    endtask

    initial begin
        // reset
        step();
        check_ifid("reset", 32'h0, NOP, 1'b0, 32'h0);
        check_imem("reset", 32'h0, 1'b1);
        check("reset.hi_addr", hi_addr, 32'hFFFFFFFC);

        // three back-to-back fetches
        rst = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hAAAA0001;
        step();
        check_ifid("fetchA", 32'd4, 32'hAAAA0001, 1'b1, 32'd1);
        check_imem("fetchA", 32'd4, 1'b1);
        check("wrap.hi_pc4", hi_pc4, 32'h0);
        check("wrap.hi_addr", hi_addr, 32'h0);
        imem_rdata = 32'hBBBB0002;
        step();
        check_ifid("fetchB", 32'd8, 32'hBBBB0002, 1'b1, 32'd2);
        imem_rdata = 32'hCCCC0003;
        step();
        check_ifid("fetchC", 32'd12, 32'hCCCC0003, 1'b1, 32'd3);
        check_imem("fetchC", 32'd12, 1'b1);

        // stall with a word in flight -> skid, HOLD
        stall = 1'b1;
        imem_rdata = 32'h58580004;
        step();
        check_ifid("hold0", 32'd12, 32'hCCCC0003, 1'b1, 32'd3);
        check_imem("hold0", 32'd16, 1'b0);
        imem_rdata = 32'hDEADBEEF;
        step();
        step();
        check_ifid("hold2", 32'd12, 32'hCCCC0003, 1'b1, 32'd3);
        check_imem("hold2", 32'd16, 1'b0);
        stall = 1'b0;
        imem_ready = 1'b0;
        step();
        check_ifid("release", 32'd16, 32'h58580004, 1'b1, 32'd4);
        check_imem("release", 32'd16, 1'b1);

        // memory not ready -> bubbles, pc holds
        step();
        check_ifid("bubble1", 32'd20, NOP, 1'b0, 32'd4);
        check_imem("bubble1", 32'd16, 1'b1);
        step();
        check_ifid("bubble2", 32'd20, NOP, 1'b0, 32'd4);
        check_imem("bubble2", 32'd16, 1'b1);
        stall = 1'b1;
        step();
        check_ifid("notrdy_stall", 32'd20, NOP, 1'b0, 32'd4);
        check_imem("notrdy_stall", 32'd16, 1'b1);
        stall = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hD0D00005;
        step();
        check_ifid("fetchD", 32'd20, 32'hD0D00005, 1'b1, 32'd5);

        // branch while in HOLD with stall held
        stall = 1'b1;
        imem_rdata = 32'hE0E00006;
        step();
        check_imem("holdE", 32'd24, 1'b0);
        branch_taken = 1'b1;
        branch_target = 32'h00000103;
        step();
        check_ifid("br_hold", 32'h0, NOP, 1'b0, 32'd5);
        check_imem("br_hold", 32'h100, 1'b1);
        branch_taken = 1'b0;
        stall = 1'b0;
        imem_rdata = 32'hF0F00007;
        step();
        check_ifid("after_br", 32'h104, 32'hF0F00007, 1'b1, 32'd6);

        // branch beats a ready fetch
        branch_taken = 1'b1;
        branch_target = 32'h00000200;
        imem_rdata = 32'h11110008;
        step();
        check_ifid("br_fetch", 32'h0, NOP, 1'b0, 32'd6);
        check_imem("br_fetch", 32'h200, 1'b1);
        branch_taken = 1'b0;

        // counter wrap
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        check("cnt_preset", fetch_count, 32'hFFFFFFFF);
        imem_rdata = 32'h22220009;
        step();
        check_ifid("cnt_wrap", 32'h204, 32'h22220009, 1'b1, 32'h0);

        // reset in HOLD, with branch and stall also asserted
        stall = 1'b1;
        imem_rdata = 32'h3333000A;
        step();
        check_imem("holdI", 32'h208, 1'b0);
        rst = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h00000400;
        step();
        check_ifid("rst_hold", 32'h0, NOP, 1'b0, 32'h0);
        check_imem("rst_hold", 32'h0, 1'b1);
        rst = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        imem_rdata = 32'h4444000B;
        step();
        check_ifid("resume", 32'd4, 32'h4444000B, 1'b1, 32'd1);
        check_imem("resume", 32'd4, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
